nested_loop_counter: RTL

//  Multi-level loop counter: NUM_LOOPS nested counters, loop 0 innermost, each with its own bound.

---
 rtl/nested_loop_counter.sv | 95 +++++++++
 1 files changed

// File: rtl/nested_loop_counter.sv
// Multi-level nested loop counter with per-level bounds latched at start.
// Level 0 is innermost. Provides start/busy/done sequencing and per-level wrap flags.
module nested_loop_counter #(
    parameter int NUM_LOOPS   = 3,
    parameter int COUNTER_WID = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             en,
    input  logic [NUM_LOOPS*COUNTER_WID-1:0] config_MAX_COUNTS,
    output logic [NUM_LOOPS*COUNTER_WID-1:0] counts,
    output logic                             busy,
    output logic                             last,
    output logic [NUM_LOOPS-1:0]             wrap,
    output logic                             done
);

    localparam int              W   = COUNTER_WID;
    localparam int              N   = NUM_LOOPS * COUNTER_WID;
    localparam logic [W-1:0]    ONE = W'(1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t               r_state;
    logic [N-1:0]         r_bounds;
    logic [N-1:0]         r_counts;
    logic                 r_done;

    logic [NUM_LOOPS-1:0] w_at_max;
    logic [NUM_LOOPS-1:0] w_lower_max;
    logic [N-1:0]         w_next_counts;

    for (genvar g = 0; g < NUM_LOOPS; g++) begin : g_lvl
        logic [W-1:0] w_cnt;
        logic [W-1:0] w_bnd;

        assign w_cnt = r_counts[g*W +: W];
        assign w_bnd = r_bounds[g*W +: W];

        // A zero bound behaves as a bound of one: the index is pinned at 0.
        assign w_at_max[g] = (w_bnd == '0) ? (w_cnt == '0) : (w_cnt == w_bnd - ONE);

        if (g == 0) begin : g_first
            assign w_lower_max[g] = 1'b1;
        end else begin : g_upper
            assign w_lower_max[g] = &w_at_max[g-1:0];
        end

        assign w_next_counts[g*W +: W] = !w_lower_max[g] ? w_cnt :
                                         (w_at_max[g] ? '0 : w_cnt + ONE);

        assign wrap[g] = busy & en & w_lower_max[g] & w_at_max[g];
    end

    assign busy   = (r_state == S_RUN);
    assign last   = busy & (&w_at_max);
    assign counts = r_counts;
    assign done   = r_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bounds <= '0;
            r_counts <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bounds <= config_MAX_COUNTS;
                        r_counts <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (en) begin
                        // On the final step every level wraps, so counts return to zero.
                        r_counts <= w_next_counts;
                        if (&w_at_max) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
